// File: rtl/sseg_scan_decoder_if.sv
// Multiplexed seven-segment display bus: active-low segments and anode selects.
interface sseg_scan_decoder_if;
  logic [6:0] sseg;
  logic [1:0] an;

  modport master (output sseg, output an);
  modport slave  (input  sseg, input  an);
endinterface

// File: rtl/sseg_scan_decoder.sv
// Reconstructs the two hex digits shown on a scanned seven-segment bus.
// Each digit gets stability qualification, decoding, and staleness timeout.
module sseg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  sseg_scan_decoder_if.slave   bus,
  output logic [3:0]           o_digit0,
  output logic [3:0]           o_digit1,
  output logic [1:0]           o_valid,
  output logic [1:0]           o_upd,
  output logic                 o_frame,
  output logic                 o_err,
  output logic                 o_err_sticky
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]            r_an_q, r_an_qq;
  logic [6:0]            r_sseg_q, r_sseg_qq;
  logic [CW-1:0]         r_cnt;
  logic [1:0][3:0]       r_digit;
  logic [1:0][TW-1:0]    r_to;
  logic [1:0]            r_valid, r_upd, r_seen;
  logic                  r_frame, r_err, r_err_sticky;

  logic                  w_same, w_cap, w_hit, w_bad;
  logic [3:0]            w_dec;
  logic [1:0]            w_sel, w_good, w_seen_nxt;

  // Stability is judged on the registered sample, so a capture lands one edge
  // after the counter has seen STABLE_CYCLES matching samples.
  assign w_same = ({r_an_q, r_sseg_q} == {r_an_qq, r_sseg_qq});
  assign w_cap  = w_same && (r_cnt == CW'(STABLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_an_q    <= '0;
      r_an_qq   <= '0;
      r_sseg_q  <= '0;
      r_sseg_qq <= '0;
      r_cnt     <= '0;
    end else begin
      r_an_q    <= bus.an;
      r_sseg_q  <= bus.sseg;
      r_an_qq   <= r_an_q;
      r_sseg_qq <= r_sseg_q;
      if (!w_same)                         r_cnt <= CW'(1);
      else if (r_cnt != CW'(STABLE_CYCLES)) r_cnt <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_hit = 1'b1;
    w_dec = 4'h0;
    case (r_sseg_q)
      7'h40: w_dec = 4'h0;
      7'h79: w_dec = 4'h1;
      7'h24: w_dec = 4'h2;
      7'h30: w_dec = 4'h3;
      7'h19: w_dec = 4'h4;
      7'h12: w_dec = 4'h5;
      7'h02: w_dec = 4'h6;
      7'h78: w_dec = 4'h7;
      7'h00: w_dec = 4'h8;
      7'h10: w_dec = 4'h9;
      7'h08: w_dec = 4'hA;
      7'h03: w_dec = 4'hB;
      7'h46: w_dec = 4'hC;
      7'h21: w_dec = 4'hD;
      7'h06: w_dec = 4'hE;
      7'h0E: w_dec = 4'hF;
      default: w_hit = 1'b0;
    endcase
  end

  assign w_sel[0]   = (r_an_q == 2'b10);
  assign w_sel[1]   = (r_an_q == 2'b01);
  assign w_good     = (w_cap && w_hit) ? w_sel : 2'b00;
  assign w_bad      = w_cap && ((r_an_q == 2'b00) || ((w_sel != 2'b00) && !w_hit));
  assign w_seen_nxt = r_seen | w_good;

  for (genvar n = 0; n < 2; n++) begin : g_dig
    // Capture takes priority over an expiry on the same edge.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_digit[n] <= '0;
        r_to[n]    <= '0;
        r_valid[n] <= 1'b0;
      end else if (w_good[n]) begin
        r_digit[n] <= w_dec;
        r_to[n]    <= '0;
        r_valid[n] <= 1'b1;
      end else begin
        if (r_to[n] != TW'(TIMEOUT_CYCLES))     r_to[n]    <= r_to[n] + TW'(1);
        if (r_to[n] == TW'(TIMEOUT_CYCLES - 1)) r_valid[n] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_upd        <= '0;
      r_seen       <= '0;
      r_frame      <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_upd        <= w_good;
      r_err        <= w_bad;
      r_err_sticky <= r_err_sticky | w_bad;
      if (&w_seen_nxt) begin
        r_frame <= 1'b1;
        r_seen  <= '0;
      end else begin
        r_frame <= 1'b0;
        r_seen  <= w_seen_nxt;
      end
    end
  end

  assign o_digit0     = r_digit[0];
  assign o_digit1     = r_digit[1];
  assign o_valid      = r_valid;
  assign o_upd        = r_upd;
  assign o_frame      = r_frame;
  assign o_err        = r_err;
  assign o_err_sticky = r_err_sticky;
endmodule

// File: doc/sseg_scan_decoder.md
Name: sseg_scan_decoder

Overview:
- Receive-side companion to the register-bank display driver. Takes the multiplexed seven-segment bus (sseg, an) and reconstructs the two hex digits currently being shown.
- Used as an in-fabric monitor and self-check: a second board or a loopback path can read back exactly what the display presents.
- Qualifies each scanned digit for stability, decodes the segment pattern to 4 bits, flags illegal patterns, and drops stale digits when scanning stops.

Parameters:
- STABLE_CYCLES, 4: consecutive clocks an/sseg must hold unchanged before a capture. Legal range 2..255.
- TIMEOUT_CYCLES, 1024: clocks without a fresh capture of a digit before that digit's valid bit clears. Must be greater than STABLE_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- sseg  in  7  segment bus, active-low, bit0=a ... bit6=g
- an  in  2  anode select, active-low: 2'b10 = digit0, 2'b01 = digit1, 2'b11 = blank, 2'b00 = illegal
- digit0  out  4  last decoded value of digit0
- digit1  out  4  last decoded value of digit1
- valid  out  2  valid[n]=1 while digit n holds a non-stale capture
- upd  out  2  one-clock pulse on upd[n] when digit n is recaptured
- frame  out  1  one-clock pulse when both digits have been captured since the last frame pulse
- err  out  1  one-clock pulse on an illegal capture
- err_sticky  out  1  latched err; cleared only by reset

Behaviour:
- Reset: on a clk edge with rst=0, all outputs and all internal state go to 0.
  - Internal state: sample registers, stability counter, timeout counters, frame-seen bits.
- Input register: an and sseg are registered each clock into an_q and sseg_q. There is no other synchroniser.
- Stability counter (cnt, width $clog2(STABLE_CYCLES+1)):
  - If {an_q,sseg_q} equals the previous registered value, cnt increments, saturating at STABLE_CYCLES.
  - Otherwise cnt loads 1.
- Capture event: fires exactly once per stable period, on the edge where cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES.
  - Latency: outputs update on the (STABLE_CYCLES+1)th rising edge at which the raw input has been held constant. With the default of 4, that is the 5th edge.
- Capture handling by an_q:
  - 2'b11 (blank): no action.
  - 2'b00: err pulse and err_sticky set. Digits and valid are unchanged.
  - 2'b10 or 2'b01: decode sseg_q using the table below.
    - Match: update digitN, set valid[N]=1, pulse upd[N], reload timeout counter N.
    - No match: err pulse and err_sticky set. digitN, valid[N] and the timeout counter are untouched.
- Decode table (active-low, hex value of {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Timeout: each digit has a counter that increments each clock, saturating.
  - On reaching TIMEOUT_CYCLES, valid[N] is cleared. digitN holds its last value.
  - A later valid capture restores valid[N].
- Frame:
  - seen[N] is set on each valid capture of digit N.
  - When both seen bits would be 1, frame pulses on that capture edge and both seen bits clear in the same cycle.
  - Recapturing the same digit twice does not produce a frame.
- Simultaneous events: a capture and a timeout expiry for the same digit on the same edge resolve in favour of the capture, so valid stays 1.
- Reset mid-settle: the partially counted stable period is discarded. After reset is released, a capture requires a full stable period of STABLE_CYCLES+1 edges again.
- Glitch shorter than STABLE_CYCLES: no capture and no err. The counter restarts from 1 on the glitch value and again from 1 when the original value returns.

Test Plan:
- Reset pulse of 1 clock with inputs toggling -> all outputs 0. Apply an=10, sseg=7'h30 held 5 edges -> digit0=3, valid=01, upd=01 for exactly one clock, err=0.
- Alternate an=10/sseg=7'h12 and an=01/sseg=7'h0E, 8 clocks each -> digit0=5, digit1=F. frame pulses once per pair of captures. valid=11.
- Hold an=10, sseg=7'h7F (all segments off, not in table) 5 edges -> err pulses 1 clock, err_sticky=1, digit0 and valid unchanged. err_sticky stays 1 until rst=0.
- Hold an=01/sseg=7'h24 stable, insert a 2-clock glitch to sseg=7'h00 -> no upd, no err, digit1 stays 2. The 2 value is recaptured once stability restores.
- Capture digit0=A (7'h08), then hold an=11 for TIMEOUT_CYCLES+2 clocks -> valid[0] falls after 1024 clocks, digit0 still A. A new capture restores valid[0].
- Hold an=00 for 5 edges -> err pulse. Assert rst=0 after 2 of 4 stable clocks, then release -> no capture until 5 fresh stable edges.
